// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters.
// Optional lookup/mispredict statistics are enabled by defining BTB_STATS_EN.
module branch_target_predictor #(
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  lookup_valid_in,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_in,
  output logic                  hit_out,
  output logic                  predict_taken_out,
  output logic [ADDR_WIDTH-1:0] predict_target_out,
  input  logic                  update_in,
  input  logic [ADDR_WIDTH-1:0] update_pc_in,
  input  logic                  update_taken_in,
  input  logic [ADDR_WIDTH-1:0] update_target_in,
  input  logic                  mispredict_in,
  input  logic                  invalidate_in,
  output logic [31:0]           lookup_count_out,
  output logic [31:0]           mispredict_count_out
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [ENTRIES];
  logic [TAG_BITS-1:0]   tag_d [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_d [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_d [ENTRIES];

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_BITS-1:0] l_tag, u_tag;
  logic                u_hit;

  assign l_idx = lookup_pc_in[IDX_BITS+1:2];
  assign l_tag = lookup_pc_in[ADDR_WIDTH-1:IDX_BITS+2];
  assign u_idx = update_pc_in[IDX_BITS+1:2];
  assign u_tag = update_pc_in[ADDR_WIDTH-1:IDX_BITS+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign hit_out            = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign predict_taken_out  = hit_out && ctr_q[l_idx][CTR_BITS-1];
  assign predict_target_out = hit_out ? tgt_q[l_idx] : '0;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (invalidate_in) valid_d = '0;
    else if (update_in && u_hit) begin
      ctr_d[u_idx] = update_taken_in ? ((ctr_q[u_idx] == CTR_MAX) ? CTR_MAX : ctr_q[u_idx] + CTR_BITS'(1))
                                     : ((ctr_q[u_idx] == '0) ? '0 : ctr_q[u_idx] - CTR_BITS'(1));
      if (update_taken_in) tgt_d[u_idx] = update_target_in;
    end else if (update_in && update_taken_in) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      tgt_d[u_idx]   = update_target_in;
      ctr_d[u_idx]   = CTR_WT;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      ctr_q   <= '{default: CTR_WNT};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lk_cnt_q, lk_cnt_d, mp_cnt_q, mp_cnt_d;
  logic        unused;
  assign unused = ^{lookup_pc_in[1:0], update_pc_in[1:0]};

  always_comb begin
    lk_cnt_d = (lookup_valid_in && lk_cnt_q != '1) ? lk_cnt_q + 32'd1 : lk_cnt_q;
    mp_cnt_d = (update_in && mispredict_in && !invalidate_in && mp_cnt_q != '1) ? mp_cnt_q + 32'd1 : mp_cnt_q;
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      lk_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      lk_cnt_q <= lk_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign lookup_count_out     = lk_cnt_q;
  assign mispredict_count_out = mp_cnt_q;
`else
  logic unused;
  assign unused = ^{lookup_valid_in, mispredict_in, lookup_pc_in[1:0], update_pc_in[1:0]};
  assign lookup_count_out     = 32'h0;
  assign mispredict_count_out = 32'h0;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench for the BTB (default 16 entries, 2-bit counters).
module tb_branch_target_predictor;
  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        lookup_valid_in = 1'b0;
  logic [31:0] lookup_pc_in = '0;
  logic        hit_out, predict_taken_out;
  logic [31:0] predict_target_out;
  logic        update_in = 1'b0;
  logic [31:0] update_pc_in = '0;
  logic        update_taken_in = 1'b0;
  logic [31:0] update_target_in = '0;
  logic        mispredict_in = 1'b0;
  logic        invalidate_in = 1'b0;
  logic [31:0] lookup_count_out, mispredict_count_out;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } item_t;

  item_t sb[$];
  item_t e;
  int    passed = 0;
  int    total = 0;

  branch_target_predictor dut (
    .clk(clk), .reset_in(reset_in),
    .lookup_valid_in(lookup_valid_in), .lookup_pc_in(lookup_pc_in),
    .hit_out(hit_out), .predict_taken_out(predict_taken_out), .predict_target_out(predict_target_out),
    .update_in(update_in), .update_pc_in(update_pc_in), .update_taken_in(update_taken_in),
    .update_target_in(update_target_in), .mispredict_in(mispredict_in), .invalidate_in(invalidate_in),
    .lookup_count_out(lookup_count_out), .mispredict_count_out(mispredict_count_out)
  );

  always #5 clk = ~clk;

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic mp, input logic inv);
    @(negedge clk);
    update_in = 1'b1; update_pc_in = pc; update_taken_in = tk;
    update_target_in = tg; mispredict_in = mp; invalidate_in = inv;
    @(posedge clk);
    #1;
    update_in = 1'b0; mispredict_in = 1'b0; invalidate_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_in = 1'b1;
    sb.push_back('{"reset_lookup", 32'h40, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    total++;
    if ({lookup_count_out, mispredict_count_out} !== 64'h0)
      $display("FAIL reset_counts got %h/%h exp 0/0", lookup_count_out, mispredict_count_out);
    else passed++;
    @(negedge clk);
    reset_in = 1'b0;
  endtask

  task automatic test_allocate;
    do_update(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
    sb.push_back('{"alloc_hit", 32'h40, 1'b1, 1'b1, 32'h80});
    sb.push_back('{"alloc_other_idx", 32'h44, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
  endtask

  task automatic test_counter;
    logic [4:0] dir = 5'b11000;
    logic [4:0] exp_tk = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      do_update(32'h40, dir[i], 32'h80, 1'b0, 1'b0);
      sb.push_back('{$sformatf("ctr_step%0d", i), 32'h40, 1'b1, exp_tk[i], 32'h80});
      while (sb.size() > 0) begin
        e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
        if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
          $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
        else passed++;
      end
    end
  endtask

  task automatic test_conflict;
    do_update(32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
    sb.push_back('{"conflict_evicted", 32'h40, 1'b0, 1'b0, 32'h0});
    sb.push_back('{"conflict_new", 32'h80, 1'b1, 1'b1, 32'h200});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    @(negedge clk);
    update_in = 1'b1; update_pc_in = 32'h40; update_taken_in = 1'b1; update_target_in = 32'h300;
    sb.push_back('{"same_cycle_old", 32'h40, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    @(posedge clk);
    #1;
    update_in = 1'b0;
    sb.push_back('{"same_cycle_after", 32'h40, 1'b1, 1'b1, 32'h300});
    sb.push_back('{"same_cycle_evict", 32'h80, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
  endtask

  task automatic test_invalidate;
    do_update(32'h44, 1'b1, 32'h48, 1'b0, 1'b0);
    sb.push_back('{"pre_inv_hit", 32'h44, 1'b1, 1'b1, 32'h48});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    do_update(32'h100, 1'b1, 32'h500, 1'b1, 1'b1);
    sb.push_back('{"inv_miss_40", 32'h40, 1'b0, 1'b0, 32'h0});
    sb.push_back('{"inv_miss_44", 32'h44, 1'b0, 1'b0, 32'h0});
    sb.push_back('{"inv_drop_100", 32'h100, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    do_update(32'h40, 1'b1, 32'h600, 1'b0, 1'b0);
    sb.push_back('{"pre_reset_hit", 32'h40, 1'b1, 1'b1, 32'h600});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    reset_in = 1'b1;
    sb.push_back('{"async_reset", 32'h40, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
    @(negedge clk);
    reset_in = 1'b0;
    do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    sb.push_back('{"reset_no_alloc_nt", 32'h40, 1'b0, 1'b0, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); lookup_pc_in = e.pc; #1; total++;
      if ({hit_out, predict_taken_out, predict_target_out} !== {e.hit, e.taken, e.tgt})
        $display("FAIL %s pc=%h got %b/%b/%h exp %b/%b/%h", e.name, e.pc, hit_out, predict_taken_out, predict_target_out, e.hit, e.taken, e.tgt);
      else passed++;
    end
  endtask

  task automatic test_stats;
    logic [31:0] exp_lk, exp_mp;
`ifdef BTB_STATS_EN
    exp_lk = 32'd10; exp_mp = 32'd3;
`else
    exp_lk = 32'd0;  exp_mp = 32'd0;
`endif
    @(negedge clk);
    reset_in = 1'b1;
    #1;
    reset_in = 1'b0;
    @(negedge clk);
    lookup_valid_in = 1'b1;
    repeat (10) @(negedge clk);
    lookup_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) do_update(32'h200 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0);
    do_update(32'h300, 1'b1, 32'h400, 1'b0, 1'b0);
    do_update(32'h300, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    mispredict_in = 1'b1;
    @(negedge clk);
    mispredict_in = 1'b0;
    total++;
    if (lookup_count_out !== exp_lk) $display("FAIL stats_lookup got %0d exp %0d", lookup_count_out, exp_lk);
    else passed++;
    total++;
    if (mispredict_count_out !== exp_mp) $display("FAIL stats_mispredict got %0d exp %0d", mispredict_count_out, exp_mp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_conflict();
    test_invalidate();
    test_async_reset();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
